// File: rtl/hdmi_i2c_pkg.sv
// Shared types and constants for the HDMI-side I2C blocks.
package hdmi_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_e;

    localparam logic [7:0] ADV7513_ADDR_W = 8'h72;
    localparam logic [7:0] ADV7513_ADDR_R = 8'h73;
    localparam logic       I2C_ACK        = 1'b0;
    localparam logic       I2C_NACK       = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with edge, START and STOP detection on the synchronized lines.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic refclk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Idle bus is high, so every flop resets to 1 to avoid a false edge after reset.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/hdmi_i2c_target.sv
// I2C target with a 256x8 register file answering 0x72/0x73, open-drain SDA.
// wr_valid is a one-cycle strobe with no backpressure; wr_addr/wr_data are meaningful only while it is high.
module hdmi_i2c_target
    import hdmi_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] peek_addr,
    output logic [7:0] peek_data,
    output state_e     dbg_state
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .refclk    (refclk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] ack_ph_q, ack_ph_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] peek_data_q;
    logic [7:0] mem_q [256];
    logic       mem_we;
    logic [7:0] byte_in, rd_byte;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ack_ph_d   = ack_ph_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we     = 1'b0;
        byte_in    = {shift_q[6:0], sda_s};
        rd_byte    = mem_q[ptr_q];

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            ack_ph_d  = 2'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_ph_d = 2'd0;
                            case (state_q)
                                ST_ADDR: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        state_d = ST_ADDR_ACK;
                                        busy_d  = 1'b1;
                                        rw_d    = byte_in[0];
                                    end else begin
                                        state_d = ST_IGNORE;
                                    end
                                end
                                ST_REG: begin
                                    ptr_d   = byte_in;
                                    state_d = ST_REG_ACK;
                                end
                                default: begin
                                    mem_we     = 1'b1;
                                    wr_valid_d = 1'b1;
                                    wr_addr_d  = ptr_q;
                                    wr_data_d  = byte_in;
                                    ptr_d      = ptr_q + 8'd1;
                                    state_d    = ST_WDATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                // Phase 0 waits for the fall that opens the ACK slot, phase 1 for the one closing it.
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (ack_ph_q == 2'd0) begin
                            sda_oe_d = 1'b1;
                            ack_ph_d = 2'd1;
                        end else begin
                            ack_ph_d  = 2'd0;
                            bit_cnt_d = 3'd0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_d  = ST_RDATA;
                                shift_d  = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d  = ST_REG;
                                sda_oe_d = 1'b0;
                            end else begin
                                state_d  = ST_WDATA;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d  = ST_RDATA_ACK;
                            ack_ph_d = 2'd0;
                        end
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                // Release, then sample the controller's ACK, then load the next byte on the closing fall.
                ST_RDATA_ACK: begin
                    if (scl_fall && ack_ph_q == 2'd0) begin
                        sda_oe_d = 1'b0;
                        ptr_d    = ptr_q + 8'd1;
                        ack_ph_d = 2'd1;
                    end else if (scl_rise && ack_ph_q == 2'd1) begin
                        if (sda_s == I2C_NACK) state_d = ST_IGNORE;
                        else                   ack_ph_d = 2'd2;
                    end else if (scl_fall && ack_ph_q == 2'd2) begin
                        state_d   = ST_RDATA;
                        shift_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 3'd0;
                        ack_ph_d  = 2'd0;
                    end
                end
                ST_IGNORE: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            ack_ph_q    <= 2'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 8'h00;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            peek_data_q <= RESET_VAL;
            for (int i = 0; i < 256; i++) mem_q[i] <= RESET_VAL;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ack_ph_q    <= ack_ph_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            peek_data_q <= mem_q[peek_addr];
            if (mem_we) mem_q[ptr_q] <= byte_in;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign peek_data = peek_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hdmi_i2c_target.sv
// Directed bench: bit-banged I2C controller, write-event scoreboard and a register model.
module tb_hdmi_i2c_target;
    import hdmi_i2c_pkg::*;

    localparam int Q = 8;

    logic       refclk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       sda_oe, wr_valid, busy;
    logic [7:0] wr_addr, wr_data, peek_addr, peek_data;
    state_e     dbg_state;

    int         n_checks = 0;
    int         n_err = 0;
    int         oe_cnt = 0;
    int         busy_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic [7:0]  model_mem [256];
    logic [15:0] cfg_tab [31];

    assign sda_bus = sda_m & ~sda_oe;

    hdmi_i2c_target #(.DEV_ADDR(7'h39), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
        .refclk    (refclk),
        .rst       (rst),
        .scl_in    (scl_m),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .peek_addr (peek_addr),
        .peek_data (peek_data),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // monitor
    always @(negedge refclk) begin
        if (wr_valid) obs_q.push_back({wr_addr, wr_data});
        if (sda_oe)   oe_cnt = oe_cnt + 1;
        if (busy)     busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #2;
    endtask

    // driver tasks
    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic oe_ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(Q);
            scl_m = 1'b1; tick(2 * Q);
            scl_m = 1'b0; tick(Q);
        end
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        oe_ack = sda_oe;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            scl_m = 1'b1; tick(Q);
            b[i] = sda_bus;
            tick(Q);
            scl_m = 1'b0; tick(Q);
        end
        sda_m = ack; tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
        sda_m = 1'b1;
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] v);
        peek_addr = a;
        tick(1);
        v = peek_data;
    endtask

    task automatic wr_txn(input logic [7:0] ra, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input int n);
        logic       oe;
        logic [7:0] a;
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        i2c_start();
        send_byte(ADV7513_ADDR_W, oe);
        check("ack_addr", oe, 1);
        check("busy_after_addr", busy, 1);
        send_byte(ra, oe);
        check("ack_reg", oe, 1);
        a = ra;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({a, d[i]});
            model_mem[a] = d[i];
            send_byte(d[i], oe);
            check("ack_data", oe, 1);
            a = a + 8'd1;
        end
        i2c_stop();
        tick(4);
        check("busy_after_stop", busy, 0);
    endtask

    // scoreboard drain
    task automatic drain_wr(input string tag);
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check(tag, obs_q.pop_front(), exp_q.pop_front());
        check({tag, "_extra_wr"}, obs_q.size(), 0);
        check({tag, "_missing_wr"}, exp_q.size(), 0);
    endtask

    initial begin
        logic       oe;
        logic [7:0] v;
        int         oe_snap, busy_snap;

        cfg_tab = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4,
                    16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'h1702, 16'h1846, 16'hAF16,
                    16'h0100, 16'h0218, 16'h0300, 16'h0A01, 16'hD6C0, 16'h5510, 16'h5608,
                    16'h9620, 16'h3B00, 16'h4080, 16'h4C04, 16'h9480, 16'h9902, 16'hE200,
                    16'hFA7D, 16'hBA60, 16'hD03C};
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

        // reset
        rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1; peek_addr = 8'h00;
        tick(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_peek", peek_data, 8'h00);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        tick(5);

        // single write 0x98 <- 0x03
        wr_txn(8'h98, 8'h03, 8'h00, 8'h00, 1);
        drain_wr("t1_wr");
        peek(8'h98, v);
        check("t1_peek_98", v, 8'h03);

        // foreign address: no ACK, no busy, no writes
        oe_snap = oe_cnt; busy_snap = busy_cnt;
        i2c_start();
        send_byte(8'h70, oe);
        check("t2_addr_nack", oe, 0);
        send_byte(8'h11, oe);
        send_byte(8'h22, oe);
        i2c_stop();
        tick(4);
        check("t2_oe_never", oe_cnt - oe_snap, 0);
        check("t2_busy_never", busy_cnt - busy_snap, 0);
        drain_wr("t2_wr");

        // burst write wrapping the pointer
        wr_txn(8'hFE, 8'hAA, 8'hBB, 8'hCC, 3);
        drain_wr("t3_wr");
        peek(8'hFE, v); check("t3_peek_fe", v, 8'hAA);
        peek(8'hFF, v); check("t3_peek_ff", v, 8'hBB);
        peek(8'h00, v); check("t3_peek_00", v, 8'hCC);

        // random read via repeated START
        wr_txn(8'h41, 8'h10, 8'h5A, 8'h00, 2);
        drain_wr("t4_pre");
        i2c_start();
        send_byte(ADV7513_ADDR_W, oe); check("t4_ack_w", oe, 1);
        send_byte(8'h41, oe);          check("t4_ack_reg", oe, 1);
        i2c_start();
        send_byte(ADV7513_ADDR_R, oe); check("t4_ack_r", oe, 1);
        read_byte(I2C_ACK, v);         check("t4_rd0", v, model_mem[8'h41]);
        read_byte(I2C_NACK, v);        check("t4_rd1", v, model_mem[8'h42]);
        oe_snap = oe_cnt;
        read_byte(I2C_NACK, v);        check("t4_after_nack_bus", v, 8'hFF);
        check("t4_after_nack_oe", oe_cnt - oe_snap, 0);
        i2c_stop();
        tick(4);
        check("t4_busy_stop", busy, 0);
        drain_wr("t4_wr");

        // reset at bit 4 of a write data byte
        i2c_start();
        send_byte(ADV7513_ADDR_W, oe);
        send_byte(8'h10, oe);
        for (int i = 7; i >= 5; i--) begin
            sda_m = v[0] ^ i[0]; tick(Q);
            scl_m = 1'b1; tick(2 * Q);
            scl_m = 1'b0; tick(Q);
        end
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        rst = 1'b0;
        #1;
        check("t5_rst_oe", sda_oe, 0);
        tick(2);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_state", dbg_state, ST_IDLE);
        sda_m = 1'b1; scl_m = 1'b1;
        tick(Q);
        rst = 1'b1;
        tick(Q);
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        peek(8'h98, v); check("t5_peek_98", v, 8'h00);
        peek(8'hFE, v); check("t5_peek_fe", v, 8'h00);
        peek(8'h00, v); check("t5_peek_00", v, 8'h00);
        peek(8'h42, v); check("t5_peek_42", v, 8'h00);
        drain_wr("t5_wr");

        // configuration sequence
        for (int i = 0; i < 31; i++)
            wr_txn(cfg_tab[i][15:8], cfg_tab[i][7:0], 8'h00, 8'h00, 1);
        drain_wr("t6_wr");
        peek(8'h98, v); check("t6_peek_98", v, 8'h03);
        peek(8'hFA, v); check("t6_peek_fa", v, 8'h7D);
        peek(8'hAF, v); check("t6_peek_af", v, 8'h16);
        peek(8'h41, v); check("t6_peek_41", v, model_mem[8'h41]);

        // report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hdmi_i2c_target.md
Name: hdmi_i2c_target

Overview:
- I2C target (responder) with a 256 x 8 register file. It answers the 8-bit write address 0x72 / read address 0x73, the same address our HDMI config master drives.
- Used on-chip as a synthesizable transmitter model so the config master can be closed-loop tested, and for register read-back / loopback bring-up on the board.
- Samples SCL/SDA oversampled on refclk; drives SDA open-drain only.
- Exposes a write-event stream and a peek port to local logic.

Parameters:
- DEV_ADDR, 7'h39, 7-bit target address (0x72 >> 1).
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (minimum 2).
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- refclk  in  1  system clock; must be at least 8x the SCL frequency.
- rst  in  1  asynchronous, active-low reset.
- scl_in  in  1  raw SCL from pad.
- sda_in  in  1  raw SDA from pad.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- wr_valid  out  1  one-cycle pulse per accepted data byte.
- wr_addr  out  8  register index of that write.
- wr_data  out  8  byte written.
- busy  out  1  high from START with address match until STOP or abort.
- peek_addr  in  8  local read index.
- peek_data  out  8  reg[peek_addr], registered, 1-cycle latency.

Behaviour:
- Reset:
  - sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, peek_data=RESET_VAL.
  - All registers = RESET_VAL; reg pointer=0; state=IDLE; synchronizer flops=1.
- Conditions, evaluated on synchronized signals with a 1-cycle-delayed copy:
  - START = SDA 1->0 while SCL=1.
  - STOP = SDA 0->1 while SCL=1.
  - Data bits are sampled on the synchronized SCL rising edge, MSB first.
  - sda_oe changes only on the synchronized SCL falling edge.
- START or STOP is detected in any state and takes priority over bit sampling in the same cycle.
  - START -> ADDR, bit counter cleared, sda_oe=0.
  - STOP -> IDLE, busy=0, sda_oe=0.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR:
  - After 8 bits: if bits[7:1]==DEV_ADDR, ACK and go to ADDR_ACK, busy=1.
  - On mismatch: no ACK, go to IGNORE.
  - ADDR_ACK: pull sda_oe high on the next SCL fall, release on the following fall.
  - After the ACK: R/W=0 -> REG; R/W=1 -> RDATA.
- REG: 8 bits load the pointer, then ACK, then WDATA.
- WDATA:
  - Each byte is written to reg[pointer].
  - wr_valid pulses in the cycle of the 8th rising edge, with wr_addr=pointer and wr_data=byte.
  - Pointer increments mod 256 (0xFF wraps to 0x00), then ACK.
  - Every write byte is ACKed; none are refused.
- RDATA:
  - Shift register loads reg[pointer] at the SCL fall that ends the ACK slot.
  - On each falling edge, sda_oe = ~bit (MSB first).
  - After 8 bits, sda_oe is released, pointer increments mod 256, and the controller's ACK bit is sampled on the 9th rising edge.
  - ACK (0) -> RDATA with the next byte.
  - NACK (1) -> IGNORE until STOP/START.
- Repeated START keeps the pointer, which enables random read (write pointer, Sr, read).
- IGNORE: sda_oe=0, busy unchanged; only START/STOP exit.
- A write-port byte and a same-cycle peek of the same index return the old value; the new value appears the next cycle.
- Reset mid-transfer: SDA released immediately (asynchronous); the partial byte is discarded.
- SCL glitches shorter than SYNC_STAGES+1 refclk cycles are not rejected; stated bus-timing limit.

Decomposition:
- Shared package hdmi_i2c_pkg:
  - state enum;
  - ADV7513_ADDR_W=8'h72, ADV7513_ADDR_R=8'h73;
  - I2C_ACK=1'b0, I2C_NACK=1'b1.
- One sub-module: i2c_line_sync.
  - Synchronizer plus edge/START/STOP detector.
  - Outputs: scl_rise, scl_fall, start_det, stop_det, sda_s.
  - Shared with any future I2C block.

Test Plan:
- Write 0x72, 0x98, 0x03, STOP.
  - sda_oe=1 for all three ACK slots; wr_valid pulses once with wr_addr=0x98, wr_data=0x03.
  - peek_addr=0x98 gives peek_data=0x03 one cycle later.
- Address 0x70, then 2 bytes.
  - sda_oe stays 0 for the whole transfer, no wr_valid, busy=0.
- Burst write 0x72, 0xFE, 0xAA, 0xBB, 0xCC.
  - reg[FE]=AA, reg[FF]=BB, reg[00]=CC.
  - Three wr_valid pulses with wr_addr FE, FF, 00.
- Random read after a preload of reg[41]=0x10, reg[42]=0x5A.
  - Stimulus: 0x72, 0x41, Sr, 0x73, controller ACK, then NACK.
  - SDA returns 0x10 then 0x5A; sda_oe=0 after the NACK until STOP.
- rst asserted low at bit 4 of a WDATA byte.
  - sda_oe=0 immediately, no wr_valid, all registers 0x00.
  - A new full transaction after release works.
- Run the config master's 31-entry 0x72 sequence against this block.
  - Every byte is ACKed; reg[0x98]=0x03, reg[0xFA]=0x7D, reg[0xAF]=0x16 at completion.
